// File: rtl/paddle_controller.sv
// paddle_controller: turns one player's raw up/down buttons into the 8-bit
// paddle top position used by the ball engine for collision.
//
// Pipeline per button: 2-FF synchroniser -> stable-count debouncer.
// A free-running divider produces a step pulse every STEP_DIV cycles.
// On each step, the motion FSM (IDLE/UP/DOWN) moves the paddle by the
// current speed and clamps it to [MIN_X, MAX_X-PADDLE_HEIGHT]. Holding one
// direction for ACCEL_STEPS steps raises the speed, up to MAX_SPEED.
//
// Optional feature, macro PADDLE_AUTO_EN: adds auto_mode/ball_x. In auto mode
// the paddle tracks the ball at speed 1 and the buttons are ignored.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-low reset
//   btn_up     in   raw async up button (decreases paddle_x)
//   btn_down   in   raw async down button (increases paddle_x)
//   auto_mode  in   (PADDLE_AUTO_EN only) track ball_x instead of buttons
//   ball_x     in   (PADDLE_AUTO_EN only) [7:0] ball vertical position
//   paddle_x   out  [7:0] paddle top position
//   at_limit   out  high while paddle_x is at either end of its range
module paddle_controller #(
  parameter int MIN_X           = 0,
  parameter int MAX_X           = 239,
  parameter int PADDLE_HEIGHT   = 40,
  parameter int START_X         = 100,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV        = 4,
  parameter int ACCEL_STEPS     = 8,
  parameter int MAX_SPEED       = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
`ifdef PADDLE_AUTO_EN
  input  logic       auto_mode,
  input  logic [7:0] ball_x,
`endif
  output logic [7:0] paddle_x,
  output logic       at_limit
);

  localparam int MAX_POS = MAX_X - PADDLE_HEIGHT;
  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW      = $clog2(ACCEL_STEPS + 1);
  localparam int SPW     = $clog2(MAX_SPEED + 1);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } state_e;

  // Synchronisers
  logic           up_meta_q, up_sync_q, dn_meta_q, dn_sync_q;
  // Debouncers
  logic           up_db_q, up_db_d, dn_db_q, dn_db_d;
  logic [DBW-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  // Step divider
  logic [STW-1:0] step_cnt_q, step_cnt_d;
  logic           step_tick;
  // Motion
  state_e         state_q, state_d, req;
  logic [SPW-1:0] speed_q, speed_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [7:0]     pos_q, pos_d;
  logic           lim_q, lim_d;
  int             nxt;
`ifdef PADDLE_AUTO_EN
  logic           auto_q;
  int             tgt;
`endif

  // Debounce: counter only runs while the synced level disagrees with the
  // accepted level; reaching the threshold accepts the new level.
  always_comb begin
    up_db_d  = up_db_q;
    up_cnt_d = '0;
    if (up_sync_q != up_db_q) begin
      if (int'(up_cnt_q) + 1 >= DEBOUNCE_CYCLES) up_db_d = up_sync_q;
      else up_cnt_d = up_cnt_q + DBW'(1);
    end
    dn_db_d  = dn_db_q;
    dn_cnt_d = '0;
    if (dn_sync_q != dn_db_q) begin
      if (int'(dn_cnt_q) + 1 >= DEBOUNCE_CYCLES) dn_db_d = dn_sync_q;
      else dn_cnt_d = dn_cnt_q + DBW'(1);
    end
  end

  always_comb begin
    step_tick  = (int'(step_cnt_q) == STEP_DIV - 1);
    step_cnt_d = step_tick ? '0 : step_cnt_q + STW'(1);
  end

  always_comb begin
    speed_d = speed_q;
    hold_d  = hold_q;
    pos_d   = pos_q;
    nxt     = int'(pos_q);
    case ({up_db_q, dn_db_q})
      2'b10:   req = UP;
      2'b01:   req = DOWN;
      default: req = IDLE;
    endcase
`ifdef PADDLE_AUTO_EN
    tgt = int'(ball_x) + 5 - PADDLE_HEIGHT / 2;
    if (tgt < MIN_X) tgt = MIN_X;
    if (tgt > MAX_POS) tgt = MAX_POS;
    if (auto_mode) begin
      if (int'(pos_q) > tgt) req = UP;
      else if (int'(pos_q) < tgt) req = DOWN;
      else req = IDLE;
    end else if (auto_q) begin
      req = IDLE;
    end
`endif
    state_d = req;

    // A direction change restarts acceleration before any move this edge,
    // so a coincident step already uses speed 1.
    if (req != state_q) begin
      speed_d = SPW'(1);
      hold_d  = '0;
    end

    if (step_tick && req != IDLE) begin
      if (req == UP) begin
        nxt = int'(pos_q) - int'(speed_d);
        if (nxt < MIN_X) nxt = MIN_X;
      end else begin
        nxt = int'(pos_q) + int'(speed_d);
        if (nxt > MAX_POS) nxt = MAX_POS;
      end
      pos_d = 8'(nxt);
      if (int'(hold_d) + 1 >= ACCEL_STEPS) begin
        hold_d = '0;
        if (int'(speed_d) < MAX_SPEED) speed_d = speed_d + SPW'(1);
      end else begin
        hold_d = hold_d + HW'(1);
      end
    end

`ifdef PADDLE_AUTO_EN
    if (auto_mode || auto_q) begin
      speed_d = SPW'(1);
      hold_d  = '0;
    end
`endif
    lim_d = (int'(pos_d) == MIN_X) || (int'(pos_d) == MAX_POS);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      up_meta_q  <= 1'b0;
      up_sync_q  <= 1'b0;
      dn_meta_q  <= 1'b0;
      dn_sync_q  <= 1'b0;
      up_db_q    <= 1'b0;
      dn_db_q    <= 1'b0;
      up_cnt_q   <= '0;
      dn_cnt_q   <= '0;
      step_cnt_q <= '0;
      state_q    <= IDLE;
      speed_q    <= SPW'(1);
      hold_q     <= '0;
      pos_q      <= 8'(START_X);
      lim_q      <= (START_X == MIN_X) || (START_X == MAX_POS);
`ifdef PADDLE_AUTO_EN
      auto_q     <= 1'b0;
`endif
    end else begin
      up_meta_q  <= btn_up;
      up_sync_q  <= up_meta_q;
      dn_meta_q  <= btn_down;
      dn_sync_q  <= dn_meta_q;
      up_db_q    <= up_db_d;
      dn_db_q    <= dn_db_d;
      up_cnt_q   <= up_cnt_d;
      dn_cnt_q   <= dn_cnt_d;
      step_cnt_q <= step_cnt_d;
      state_q    <= state_d;
      speed_q    <= speed_d;
      hold_q     <= hold_d;
      pos_q      <= pos_d;
      lim_q      <= lim_d;
`ifdef PADDLE_AUTO_EN
      auto_q     <= auto_mode;
`endif
    end
  end

  assign paddle_x = pos_q;
  assign at_limit = lim_q;

endmodule
